dac_seq_ctrl: RTL and testbench

Run-time controller for the DAC output path. It replaces the fixed divide-by-constant counter and free-running ramp with a configurable sequencer. The sequencer generates dac_clk from the fabric PLL clock with a programmable divide factor and drives dout from a selectable pattern source. It runs either for a programmed number of samples or continuously until stopped. It sits between the PLL/clock-control output and the DAC pins; a host or test FSM configures and starts it through a valid/ready handshake.

---
 rtl/dac_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_dac_seq_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_seq_ctrl.sv
// dac_seq_ctrl: configurable DAC sequencer.
// Divides the fabric clock by N to form dac_clk and drives dout from a
// selectable pattern source (ramp-up, square, constant, ramp-down). A run
// lasts for a programmed number of samples, or continues until stopped.
module dac_seq_ctrl #(
  parameter int DOUT_WIDTH = 8,
  parameter int DIV_WIDTH  = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  input  logic [1:0]            cfg_mode,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [DOUT_WIDTH-1:0] cfg_const,
  input  logic                  start,
  input  logic                  stop,
  output logic                  busy,
  output logic                  done,
  output logic                  dac_clk,
  output logic [DOUT_WIDTH-1:0] dout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] MODE_UP    = 2'd0;
  localparam logic [1:0] MODE_SQ    = 2'd1;
  localparam logic [1:0] MODE_CONST = 2'd2;
  localparam logic [1:0] MODE_DOWN  = 2'd3;

  state_t                r_state;
  logic [DIV_WIDTH-1:0]  r_div;
  logic [1:0]            r_mode;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [DOUT_WIDTH-1:0] r_const;
  logic [DIV_WIDTH-1:0]  r_cnt;
  logic [LEN_WIDTH-1:0]  r_samp;
  logic                  r_dac_clk;
  logic [DOUT_WIDTH-1:0] r_dout;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_cfg_ready;

  logic                  w_cfg_take;
  logic [DIV_WIDTH-1:0]  w_div_sat;
  logic [1:0]            w_mode_eff;
  logic [DOUT_WIDTH-1:0] w_const_eff;
  logic [DIV_WIDTH-1:0]  w_half_m1;
  logic                  w_last;
  logic [LEN_WIDTH-1:0]  w_samp_inc;
  logic                  w_len_hit;
  logic [DOUT_WIDTH-1:0] w_dout_init;
  logic [DOUT_WIDTH-1:0] w_dout_step;

  // A config handshake only completes while idle; divide factors below 2 clamp to 2.
  assign w_cfg_take  = cfg_valid && r_cfg_ready;
  assign w_div_sat   = (cfg_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : cfg_div;
  // A run started in the same cycle as a handshake uses the presented config.
  assign w_mode_eff  = w_cfg_take ? cfg_mode  : r_mode;
  assign w_const_eff = w_cfg_take ? cfg_const : r_const;

  // Divider decode: rise after cnt == N/2-1, fall and sample advance at cnt == N-1.
  assign w_half_m1   = (r_div >> 1) - DIV_WIDTH'(1);
  assign w_last      = (r_cnt == (r_div - DIV_WIDTH'(1)));
  assign w_samp_inc  = r_samp + LEN_WIDTH'(1);
  assign w_len_hit   = (r_len != '0) && (w_samp_inc == r_len);

  // Pattern start value and per-sample update.
  always_comb begin
    w_dout_init = '0;
    w_dout_step = r_dout;
    case (w_mode_eff)
      MODE_UP:    w_dout_init = '0;
      MODE_SQ:    w_dout_init = '0;
      MODE_CONST: w_dout_init = w_const_eff;
      MODE_DOWN:  w_dout_init = '1;
      default:    w_dout_init = '0;
    endcase
    case (r_mode)
      MODE_UP:    w_dout_step = r_dout + DOUT_WIDTH'(1);
      MODE_SQ:    w_dout_step = ~r_dout;
      MODE_CONST: w_dout_step = r_dout;
      MODE_DOWN:  w_dout_step = r_dout - DOUT_WIDTH'(1);
      default:    w_dout_step = r_dout;
    endcase
  end

  // Sequencer FSM with divider, sample counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_div       <= DIV_WIDTH'(2);
      r_mode      <= MODE_UP;
      r_len       <= '0;
      r_const     <= '0;
      r_cnt       <= '0;
      r_samp      <= '0;
      r_dac_clk   <= 1'b0;
      r_dout      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_dac_clk <= 1'b0;
          if (w_cfg_take) begin
            r_div   <= w_div_sat;
            r_mode  <= cfg_mode;
            r_len   <= cfg_len;
            r_const <= cfg_const;
          end
          if (start && !stop) begin
            r_state     <= S_RUN;
            r_cnt       <= '0;
            r_samp      <= '0;
            r_busy      <= 1'b1;
            r_cfg_ready <= 1'b0;
            r_dout      <= w_dout_init;
          end
        end
        S_RUN, S_FLUSH: begin
          if (w_last) begin
            r_cnt     <= '0;
            r_dac_clk <= 1'b0;
            r_samp    <= w_samp_inc;
            if (w_len_hit || (r_state == S_FLUSH)) begin
              // Final fall: dout keeps the last sampled value.
              r_state     <= S_IDLE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_cfg_ready <= 1'b1;
            end else begin
              r_dout <= w_dout_step;
              if (stop) r_state <= S_FLUSH;
            end
          end else begin
            r_cnt <= r_cnt + DIV_WIDTH'(1);
            if (r_cnt == w_half_m1) r_dac_clk <= 1'b1;
            if (stop && (r_state == S_RUN)) r_state <= S_FLUSH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dac_clk   = r_dac_clk;
  assign dout      = r_dout;

endmodule

// File: tb/tb_dac_seq_ctrl.sv
// tb_dac_seq_ctrl: scoreboard bench for dac_seq_ctrl.
// Expected dout values at each dac_clk rise are queued when a run is started
// and popped by a negedge monitor, which also checks high/low times.
module tb_dac_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_div;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_len;
  logic [7:0]  cfg_const;
  logic        start;
  logic        stop;
  logic        busy;
  logic        done;
  logic        dac_clk;
  logic [7:0]  dout;

  dac_seq_ctrl #(.DOUT_WIDTH(8), .DIV_WIDTH(8), .LEN_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_mode  (cfg_mode),
    .cfg_len   (cfg_len),
    .cfg_const (cfg_const),
    .start     (start),
    .stop      (stop),
    .busy      (busy),
    .done      (done),
    .dac_clk   (dac_clk),
    .dout      (dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  int exp_hi = 0;
  int exp_lo = 0;
  int rise_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  // Monitor: dout at each rise, high/low widths, done pulses.
  logic prev_clk = 1'b0;
  int   hi_cnt = 0;
  int   lo_cnt = 0;
  bit   first_rise = 1'b1;
  logic [7:0] exp_v;

  always @(negedge clk) begin
    if (rst) begin
      prev_clk   = 1'b0;
      hi_cnt     = 0;
      lo_cnt     = 0;
      first_rise = 1'b1;
    end else begin
      if (dac_clk && !prev_clk) begin
        rise_cnt++;
        if (exp_q.size() == 0) begin
          check("extra_rise", 1, 0);
        end else begin
          exp_v = exp_q.pop_front();
          check("dout_rise", int'(dout), int'(exp_v));
        end
        if (!first_rise) check("low_time", lo_cnt, exp_lo);
        first_rise = 1'b0;
        hi_cnt = 1;
      end else if (!dac_clk && prev_clk) begin
        check("high_time", hi_cnt, exp_hi);
        lo_cnt = 1;
      end else if (dac_clk) begin
        hi_cnt++;
      end else begin
        lo_cnt++;
      end
      if (done) done_cnt++;
      if (!busy) first_rise = 1'b1;
      prev_clk = dac_clk;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected rise values and start a run.
  task automatic start_run(input int div, input int mode, input int len, input int cst,
                           input int npush, input bit use_cfg);
    int n;
    logic [7:0] v;
    n = (div < 2) ? 2 : div;
    exp_hi = (n + 1) / 2;
    exp_lo = n / 2;
    case (mode)
      0, 1:    v = 8'h00;
      2:       v = cst[7:0];
      default: v = 8'hFF;
    endcase
    for (int i = 0; i < npush; i++) begin
      exp_q.push_back(v);
      case (mode)
        0:       v = v + 8'd1;
        1:       v = (v == 8'h00) ? 8'hFF : 8'h00;
        2:       v = v;
        default: v = v - 8'd1;
      endcase
    end
    if (use_cfg) begin
      cfg_div   = div[7:0];
      cfg_mode  = mode[1:0];
      cfg_len   = len[15:0];
      cfg_const = cst[7:0];
      cfg_valid = 1'b1;
    end
    start = 1'b1;
    tick();
    cfg_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    int d0;
    seen = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, int'(seen), 1);
    check({tag, "_busy_end"}, int'(busy), 0);
    check({tag, "_ready_end"}, int'(cfg_ready), 1);
    check({tag, "_dacclk_end"}, int'(dac_clk), 0);
    check({tag, "_rises_left"}, exp_q.size(), 0);
    tick();
    check({tag, "_done_single"}, int'(done), 0);
    check({tag, "_done_count"}, done_cnt - d0, 1);
  endtask

  int base;
  int saved_done;
  bit reached;

  initial begin
    rst       = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = 8'd0;
    cfg_mode  = 2'd0;
    cfg_len   = 16'd0;
    cfg_const = 8'd0;
    start     = 1'b0;
    stop      = 1'b0;
    #2 rst = 1'b1;
    #2;
    check("rst_dac_clk", int'(dac_clk), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // N=4 ramp-up, 3 samples
    start_run(4, 0, 3, 0, 3, 1'b1);
    check("t1_busy", int'(busy), 1);
    check("t1_ready_run", int'(cfg_ready), 0);
    wait_done("t1", 100);

    // N=5 square, 4 samples
    start_run(5, 1, 4, 0, 4, 1'b1);
    wait_done("t2", 100);

    // cfg_div of 0 and 1 behave as N=2
    start_run(0, 0, 2, 0, 2, 1'b1);
    wait_done("t3a", 50);
    start_run(1, 0, 2, 0, 2, 1'b1);
    wait_done("t3b", 50);

    // Continuous ramp-up N=2 past the 0xFF wrap, then stop
    base = rise_cnt;
    start_run(2, 0, 0, 0, 301, 1'b1);
    reached = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (rise_cnt - base >= 300) begin
        reached = 1'b1;
        break;
      end
    end
    check("t4_reach_300", int'(reached), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done("t4", 20);
    repeat (10) tick();
    check("t4_total_rises", rise_cnt - base, 301);

    // Ramp-down, then constant with an attempted mid-run reconfiguration
    start_run(3, 3, 2, 0, 2, 1'b1);
    wait_done("t5a", 50);
    start_run(3, 2, 2, 8'h5A, 2, 1'b1);
    tick();
    cfg_div   = 8'd7;
    cfg_mode  = 2'd0;
    cfg_len   = 16'd9;
    cfg_const = 8'h11;
    cfg_valid = 1'b1;
    #1;
    check("t5_ready_in_run", int'(cfg_ready), 0);
    tick();
    cfg_valid = 1'b0;
    wait_done("t5b", 50);
    // A start without handshake reuses the latched (unchanged) config
    start_run(3, 2, 2, 8'h5A, 2, 1'b0);
    wait_done("t5c", 50);

    // Reset mid-run while dac_clk is high
    start_run(8, 0, 0, 0, 4, 1'b1);
    reached = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (dac_clk) begin
        reached = 1'b1;
        break;
      end
    end
    check("t6_dac_clk_high", int'(reached), 1);
    saved_done = done_cnt;
    #2 rst = 1'b1;
    #1;
    check("t6_rst_dac_clk", int'(dac_clk), 0);
    check("t6_rst_dout", int'(dout), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_done", int'(done), 0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("t6_no_done", done_cnt, saved_done);

    // start together with stop in IDLE is ignored
    base  = rise_cnt;
    start = 1'b1;
    stop  = 1'b1;
    repeat (6) tick();
    check("t7_busy", int'(busy), 0);
    check("t7_ready", int'(cfg_ready), 1);
    check("t7_no_rise", rise_cnt - base, 0);
    start = 1'b0;
    stop  = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
